// File: rtl/pattern_pkg.sv
// Shared pattern-generator definitions: pattern modes, FSM states and the LFSR feedback taps.
// Pure declarations, no latency; used by the RTL and by the reference model alike.
package pattern_pkg;

  // Feedback bit is the XOR of D[7], D[5], D[4] and D[3].
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    MODE_INC  = 2'b00,
    MODE_DEC  = 2'b01,
    MODE_LFSR = 2'b10,
    MODE_WALK = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // An all-zero word would lock up the LFSR and walking-one patterns, so they start from 01.
  function automatic logic [7:0] first_word(input mode_e m, input logic [7:0] s);
    if (s == 8'h00 && (m == MODE_LFSR || m == MODE_WALK)) return 8'h01;
    return s;
  endfunction

endpackage

// File: rtl/pattern_step.sv
// Next-word function of the pattern generator: increment, decrement, LFSR shift or rotate-left.
// Purely combinational, zero latency, no flow control.
module pattern_step
  import pattern_pkg::*;
(
  input  mode_e      i_mode,
  input  logic [7:0] i_d,
  output logic [7:0] o_next
);

  always_comb begin
    o_next = i_d;
    case (i_mode)
      MODE_INC:  o_next = i_d + 8'd1;
      MODE_DEC:  o_next = i_d - 8'd1;
      MODE_LFSR: o_next = {i_d[6:0], ^(i_d & LFSR_TAPS)};
      MODE_WALK: o_next = {i_d[6:0], i_d[7]};
      default:   o_next = i_d;
    endcase
  end

endmodule

// File: rtl/d_pattern_gen.sv
// Burst pattern generator: IDLE -> RUN -> DONE, first word one cycle after start, all outputs registered.
// No backpressure: words stream every RUN cycle until the burst length is reached or stop aborts it.
module d_pattern_gen
  import pattern_pkg::*;
#(
  parameter int WIDTH = 8
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [7:0]       burst_len,
  output logic [WIDTH-1:0] D,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  state_e     r_state;
  mode_e      r_mode;
  logic [7:0] r_len;
  logic [7:0] r_cnt;
  logic [7:0] r_d;
  logic       r_valid;
  logic       r_busy;
  logic       r_done;

  state_e     w_state_nxt;
  mode_e      w_mode_nxt;
  logic [7:0] w_len_nxt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] w_d_nxt;
  logic       w_valid_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic [7:0] w_step;

  pattern_step u_step (
    .i_mode (r_mode),
    .i_d    (r_d),
    .o_next (w_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_INC;
      r_len   <= 8'd0;
      r_cnt   <= 8'd0;
      r_d     <= 8'd0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_len   <= w_len_nxt;
      r_cnt   <= w_cnt_nxt;
      r_d     <= w_d_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_d_nxt     = r_d;
    w_valid_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_mode_nxt  = mode_e'(mode);
          w_len_nxt   = burst_len;
          w_d_nxt     = first_word(mode_e'(mode), seed);
          w_cnt_nxt   = 8'd1;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_RUN: begin
        // Abort outranks completion; a zero length never completes and the count just wraps.
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (r_len != 8'd0 && r_cnt == r_len) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_d_nxt     = w_step;
          w_cnt_nxt   = r_cnt + 8'd1;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign D     = r_d;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_d_pattern_gen.sv
// Bench for d_pattern_gen: directed bursts push expected words/done pulses into a queue,
// a negedge monitor pops and compares whatever the generator presents.
module tb_d_pattern_gen;
  import pattern_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [7:0] seed;
  logic [7:0] burst_len;
  logic [7:0] D;
  logic       valid;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       is_done;
    logic [7:0] d;
  } exp_t;
  exp_t exp_q[$];

  mode_e      m_mode = MODE_INC;
  logic [7:0] m_d    = 8'h00;
  logic [7:0] m_next;

  pattern_step u_ref (
    .i_mode (m_mode),
    .i_d    (m_d),
    .o_next (m_next)
  );

  d_pattern_gen #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .seed      (seed),
    .burst_len (burst_len),
    .D         (D),
    .valid     (valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  // Monitor: every word or done pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (valid || done) begin
      exp_t e;
      n_checks++;
      if (valid && done) begin
        n_fail++;
        $display("FAIL monitor: valid and done together, D=%h, required exclusive", D);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL monitor: unexpected output valid=%b done=%b D=%h, required none", valid, done, D);
      end else begin
        e = exp_q.pop_front();
        if (e.is_done != done || (!e.is_done && e.d !== D)) begin
          n_fail++;
          $display("FAIL monitor: got valid=%b done=%b D=%h, required done=%b D=%h",
                   valid, done, D, e.is_done, e.d);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    exp_q.push_back(exp_t'{1'b0, d});
  endtask

  task automatic push_done();
    exp_q.push_back(exp_t'{1'b1, 8'h00});
  endtask

  task automatic model_step(input mode_e m, input logic [7:0] d, output logic [7:0] n);
    m_mode = m;
    m_d    = d;
    #1;
    n = m_next;
  endtask

  task automatic model_check(input string name, input mode_e m, input logic [7:0] d,
                             input logic [7:0] req);
    logic [7:0] n;
    model_step(m, d, n);
    check(name, n, req);
  endtask

  task automatic fire(input mode_e m, input logic [7:0] s, input logic [7:0] len);
    mode      = m;
    seed      = s;
    burst_len = len;
    start     = 1'b1;
    tick(1);
    start     = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain: %0d outstanding outputs, required 0", name, exp_q.size());
      exp_q.delete();
    end
    tick(2);
  endtask

  initial begin
    logic [7:0] w;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    mode = 2'b00; seed = 8'h00; burst_len = 8'h00;
    tick(3);
    check("reset D", D, 8'h00);
    check("reset valid", {7'd0, valid}, 8'h00);
    check("reset busy", {7'd0, busy}, 8'h00);
    check("reset done", {7'd0, done}, 8'h00);
    rst = 1'b0;
    tick(1);

    model_check("model inc wrap", MODE_INC, 8'hFF, 8'h00);
    model_check("model dec wrap", MODE_DEC, 8'h00, 8'hFF);
    model_check("model lfsr", MODE_LFSR, 8'h08, 8'h11);
    model_check("model walk wrap", MODE_WALK, 8'h80, 8'h01);
    tick(1);

    // Increment with wrap, natural completion.
    push_word(8'hFE); push_word(8'hFF); push_word(8'h00); push_word(8'h01); push_done();
    fire(MODE_INC, 8'hFE, 8'd4);
    check("inc busy in run", {7'd0, busy}, 8'h01);
    drain("inc");
    check("inc idle valid", {7'd0, valid}, 8'h00);
    check("inc idle busy", {7'd0, busy}, 8'h00);
    check("inc idle D hold", D, 8'h01);

    // LFSR with zero seed starts from 01.
    push_word(8'h01); push_word(8'h02); push_word(8'h04); push_word(8'h08); push_word(8'h11);
    push_done();
    fire(MODE_LFSR, 8'h00, 8'd5);
    drain("lfsr");

    // Continuous walking-one, config changes ignored, stopped after six words.
    w = 8'h40;
    push_word(w);
    for (int i = 0; i < 5; i++) begin
      model_step(MODE_WALK, w, w);
      push_word(w);
    end
    tick(1);
    fire(MODE_WALK, 8'h40, 8'd0);
    mode = MODE_INC; seed = 8'hFF; burst_len = 8'd1;
    tick(5);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("walk stop valid", {7'd0, valid}, 8'h00);
    check("walk stop busy", {7'd0, busy}, 8'h00);
    check("walk stop done", {7'd0, done}, 8'h00);
    check("walk stop D hold", D, 8'h08);
    drain("walk");

    // Stop on the final word beats completion.
    push_word(8'h02); push_word(8'h01); push_word(8'h00);
    fire(MODE_DEC, 8'h02, 8'd3);
    tick(2);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("dec stop done", {7'd0, done}, 8'h00);
    check("dec stop busy", {7'd0, busy}, 8'h00);
    drain("dec");

    // Reset mid-burst, then start and stop together in IDLE.
    push_word(8'h10); push_word(8'h11);
    fire(MODE_INC, 8'h10, 8'd10);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid reset D", D, 8'h00);
    check("mid reset valid", {7'd0, valid}, 8'h00);
    check("mid reset busy", {7'd0, busy}, 8'h00);
    check("mid reset done", {7'd0, done}, 8'h00);
    push_word(8'h20); push_word(8'h21); push_done();
    stop = 1'b1;
    fire(MODE_INC, 8'h20, 8'd2);
    stop = 1'b0;
    check("start beats stop valid", {7'd0, valid}, 8'h01);
    check("start beats stop D", D, 8'h20);
    drain("restart");

    // start held high: ignored in RUN/DONE, new burst one cycle after IDLE.
    push_word(8'h30); push_word(8'h31); push_done();
    push_word(8'h30); push_word(8'h31); push_done();
    mode = MODE_INC; seed = 8'h30; burst_len = 8'd2; start = 1'b1;
    tick(4);
    check("held idle valid", {7'd0, valid}, 8'h00);
    check("held idle busy", {7'd0, busy}, 8'h00);
    tick(1);
    check("held rerun valid", {7'd0, valid}, 8'h01);
    check("held rerun D", D, 8'h30);
    start = 1'b0;
    drain("held");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
